frac_clk_gen: RTL

- Synthesizable, multi-channel fractional clock generator.
- Each channel runs a phase accumulator off the single system clock and produces a divided clock plus a one-cycle tick pulse.
- The output rate is programmable with sub-cycle (fractional) resolution, so frequencies like 1.25-cycle tick periods are produced with bounded ±1-cycle jitter and exact long-term average.
- Used by benches and RTL wherever a non-integer ratio of the system clock is needed.

---
 rtl/frac_clk_gen.sv | 127 ++++++++++++
 1 files changed

// File: rtl/frac_clk_gen.sv
// Multi-channel fractional clock generator: each channel owns a phase accumulator whose carry
// produces a one-cycle tick and toggles a divided clock. Increment changes take effect on a carry.
module frac_clk_gen #(
  parameter int          N_CH    = 4,
  parameter int          ACC_W   = 16,
  parameter int unsigned INC_RST = 0,
  parameter int          CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   en,
  input  logic              sync,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  output logic              cfg_err,
  output logic [N_CH-1:0]   pend,
  output logic [N_CH-1:0]   clk_out,
  output logic [N_CH-1:0]   tick
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} ch_state_e;

  logic [N_CH-1:0] cfg_hit;
  logic            sel_pend;
  logic            ch_ok;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    ch_ok    = int'(cfg_ch) < N_CH;
    sel_pend = 1'b0;
    cfg_hit  = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (int'(cfg_ch) == i) begin
        sel_pend   = pend[i];
        cfg_hit[i] = cfg_valid && !pend[i];
      end
    end
  end

  // An out-of-range index never matches a channel, so it is always ready and simply dropped.
  assign cfg_ready = !sel_pend;

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cfg_err <= 1'b0;
    else        cfg_err <= cfg_valid && !ch_ok;
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] inc_act;
    logic [ACC_W-1:0] shadow;
    logic [ACC_W:0]   sum;
    logic             carry;
    logic             pend_q;
    logic             clk_q;
    logic             tick_q;
    ch_state_e        st;

    // A channel with en low but clk_out still high finishes its high phase before stopping.
    always_comb begin
      if (en[g])      st = ST_RUN;
      else if (clk_q) st = ST_DRAIN;
      else            st = ST_IDLE;
    end

    assign sum   = {1'b0, acc} + {1'b0, inc_act};
    assign carry = sum[ACC_W];

    // NOTE: the shadow register is reset with the rest of the channel state; it is one word, not a RAM.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc     <= '0;
        inc_act <= ACC_W'(INC_RST);
        shadow  <= '0;
        pend_q  <= 1'b0;
        clk_q   <= 1'b0;
        tick_q  <= 1'b0;
      end else begin
        tick_q <= 1'b0;
        if (st == ST_IDLE) begin
          // A stopped channel has no phase to protect, so a leftover shadow is applied at once.
          acc <= '0;
          if (pend_q) begin
            inc_act <= shadow;
            pend_q  <= 1'b0;
          end
          if (cfg_hit[g]) inc_act <= cfg_inc;
        end else if (sync) begin
          acc   <= '0;
          clk_q <= 1'b0;
          if (pend_q) begin
            inc_act <= shadow;
            pend_q  <= 1'b0;
          end
          if (cfg_hit[g]) inc_act <= cfg_inc;
        end else begin
          acc <= sum[ACC_W-1:0];
          if (carry) begin
            tick_q <= 1'b1;
            clk_q  <= ~clk_q;
            if (pend_q) begin
              inc_act <= shadow;
              pend_q  <= 1'b0;
            end
            if (st == ST_DRAIN) acc <= '0;
          end
          if (cfg_hit[g]) begin
            if (inc_act == '0) begin
              inc_act <= cfg_inc;
            end else begin
              shadow <= cfg_inc;
              pend_q <= 1'b1;
            end
          end
        end
      end
    end

    assign pend[g]    = pend_q;
    assign clk_out[g] = clk_q;
    assign tick[g]    = tick_q;
  end

endmodule
